// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI mode 0 responder with one-word tx holding buffer and rx strobe
module spi_slave #(
    parameter int              DW        = 8,
    parameter logic [DW-1:0]   IDLE_WORD = DW'(8'hFF)
) (
    input  logic          clk,
    input  logic          resetb,
    input  logic          sck,
    input  logic          mosi,
    input  logic          ssb,
    output logic          miso,
    output logic          miso_oe,
    input  logic [DW-1:0] tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic          tx_underrun,
    output logic [DW-1:0] rx_data,
    output logic          rx_valid,
    output logic          busy
);
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t state, state_nx;

    logic sck_m, sck_s, sck_d;
    logic ssb_m, ssb_s, ssb_d;
    logic mosi_m, mosi_s;

    logic sck_rise, sck_fall, ssb_rise, ssb_fall;
    logic do_load, do_shift, do_sample, do_leave;
    logic tx_write;

    logic [CW-1:0] bit_cnt;
    logic [DW-1:0] tx_sh;
    logic [DW-1:0] rx_sh;
    logic [DW-1:0] tx_buf;
    logic          tx_full;

    // two-stage synchronizers plus one delayed copy for edge detection
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            sck_m  <= 1'b0;
            sck_s  <= 1'b0;
            sck_d  <= 1'b0;
            ssb_m  <= 1'b1;
            ssb_s  <= 1'b1;
            ssb_d  <= 1'b1;
            mosi_m <= 1'b0;
            mosi_s <= 1'b0;
        end else begin
            sck_m  <= sck;
            sck_s  <= sck_m;
            sck_d  <= sck_s;
            ssb_m  <= ssb;
            ssb_s  <= ssb_m;
            ssb_d  <= ssb_s;
            mosi_m <= mosi;
            mosi_s <= mosi_m;
        end
    end

    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign ssb_rise = ssb_s & ~ssb_d;
    assign ssb_fall = ~ssb_s & ssb_d;

    assign tx_ready = ~tx_full;
    assign tx_write = tx_valid & ~tx_full;
    assign busy     = ~ssb_s;

    // frame state register
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next state and per-cycle datapath strobes; leaving a frame masks sck edges
    always_comb begin
        state_nx  = state;
        do_load   = 1'b0;
        do_shift  = 1'b0;
        do_sample = 1'b0;
        do_leave  = 1'b0;
        case (state)
            IDLE: begin
                if (ssb_fall) begin
                    state_nx = ACTIVE;
                    do_load  = 1'b1;
                end
            end
            ACTIVE: begin
                if (ssb_rise) begin
                    state_nx = IDLE;
                    do_leave = 1'b1;
                end else begin
                    do_sample = sck_rise;
                    if (sck_fall) begin
                        if (bit_cnt == '0) begin
                            do_load = 1'b1;
                        end else begin
                            do_shift = 1'b1;
                        end
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // shifters, holding buffer and output registers; a load sees the buffer before a same-cycle write
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
            tx_underrun <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            bit_cnt     <= '0;
            tx_sh       <= '0;
            rx_sh       <= '0;
            tx_buf      <= '0;
            tx_full     <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            miso_oe     <= (state == ACTIVE) && !ssb_rise;

            if (tx_write) begin
                tx_buf  <= tx_data;
                tx_full <= 1'b1;
            end

            if (do_load) begin
                bit_cnt <= '0;
                if (tx_full) begin
                    tx_sh   <= tx_buf;
                    miso    <= tx_buf[DW-1];
                    tx_full <= 1'b0;
                end else begin
                    tx_sh       <= IDLE_WORD;
                    miso        <= IDLE_WORD[DW-1];
                    tx_underrun <= 1'b1;
                end
            end

            if (do_shift) begin
                tx_sh <= tx_sh << 1;
                miso  <= tx_sh[DW-2];
            end

            if (do_sample) begin
                rx_sh <= {rx_sh[DW-2:0], mosi_s};
                if (bit_cnt == CW'(DW - 1)) begin
                    rx_data  <= {rx_sh[DW-2:0], mosi_s};
                    rx_valid <= 1'b1;
                    bit_cnt  <= '0;
                end else begin
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end

            if (do_leave) begin
                miso    <= 1'b0;
                bit_cnt <= '0;
            end
        end
    end
endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder (mode 0: CPOL=0, CPHA=0, MSB first): the other end of the SPI initiator that drives ICE_SCK/ICE_MOSI/ICE_MISO and the active-low chip selects.
- Lets the FPGA act as an SPI peripheral to an external host, e.g. a second board or a bench test master.
- All pin inputs are oversampled in the system clock domain.
- Presents a one-word transmit holding buffer and a receive strobe to the CPU bus glue in SYSTEM.

Parameters:
DW, 8, bits per SPI word
IDLE_WORD, 8'hFF, word shifted out when the tx buffer is empty at a word boundary

Ports:
clk  input  1  system clock (25 MHz)
resetb  input  1  asynchronous active-low reset
sck  input  1  SPI clock from host, asynchronous
mosi  input  1  serial data from host, asynchronous
ssb  input  1  slave select, active low, asynchronous
miso  output  1  serial data to host
miso_oe  output  1  tristate enable for the MISO pad (SB_IO in top level)
tx_data  input  DW  word to transmit
tx_valid  input  1  tx_data offered
tx_ready  output  1  holding buffer empty; a write is accepted when tx_valid && tx_ready
tx_underrun  output  1  one-cycle pulse: IDLE_WORD was sent because the buffer was empty
rx_data  output  DW  last complete received word, held until the next word completes
rx_valid  output  1  one-cycle pulse: rx_data updated
busy  output  1  ssb asserted (synchronized)

Behaviour:
- Reset (resetb low, asynchronous):
  - All state clears: miso=0, miso_oe=0, tx_ready=1, tx_underrun=0, rx_data=0, rx_valid=0, busy=0, bit counter=0, shift registers=0.
  - Synchronizers reset to the idle levels: sck=0, ssb=1.
- Synchronization and edge detection:
  - sck, mosi and ssb each pass through a 2-FF synchronizer; edges are detected on the synchronized copies.
  - Host sck frequency must be ≤ clk/8, and ssb must be low ≥ 4 clk before the first sck rising edge.
- States:
  - IDLE: ssb_s high.
  - ACTIVE: ssb_s low.
  - IDLE→ACTIVE on the ssb_s falling edge. ACTIVE→IDLE on the ssb_s rising edge, taking priority over any sck edge in the same cycle.
- Entering ACTIVE:
  - Bit counter := 0.
  - Tx shifter loads the holding buffer if it is full, and the buffer is freed; otherwise it loads IDLE_WORD and pulses tx_underrun.
  - miso := shifter MSB; miso_oe := 1 one cycle later.
- sck_s rising edge in ACTIVE:
  - rx shifter := {rx shifter[DW-2:0], mosi_s}; bit counter increments.
  - When the counter was DW-1: rx_data := the completed word, rx_valid pulses for one clk (3 clk after the pin edge), and the counter wraps to 0.
- sck_s falling edge in ACTIVE:
  - Counter ≠ 0: tx shifter shifts left and miso := the new MSB.
  - Counter = 0 (word boundary): load the next word using the buffer-or-IDLE_WORD rule above.
- Tx buffer:
  - A write accepted by the tx_valid/tx_ready handshake sets it full (tx_ready=0).
  - A load in the same cycle as a write uses the buffer's prior content; the new write lands in the buffer for the next word.
- Leaving ACTIVE (ssb_s rising):
  - miso_oe := 0 and miso := 0 on the next clk.
  - A partial rx word is discarded: no rx_valid, rx_data unchanged. A partially shifted tx word is lost.
  - The holding buffer keeps any unconsumed word. Bit counter := 0.
- Extra edges are ignored:
  - sck edges while IDLE.
  - mosi changes other than at sck rising edges.
- rx has no backpressure: the consumer must capture rx_data within DW sck periods.

Test Plan:
1. Reset, then preload tx 8'hA5; host sends 8'h3C in one ssb frame → MISO bits 1,0,1,0,0,1,0,1; rx_valid pulses exactly once with rx_data=8'h3C; tx_ready back to 1 after ssb falls.
2. 3-word frame (host 01,02,03) with tx written 11, then 22 and 33, each just after tx_ready rises → host reads 11,22,33; three rx_valid pulses; tx_underrun never asserted.
3. Empty buffer at frame start and at the 2nd word boundary → host reads FF,FF; tx_underrun pulses twice.
4. ssb deasserted after 5 sck pulses → no rx_valid; rx_data keeps the previous value; miso_oe falls within 4 clk; the next full frame receives correctly with counter restarted at 0.
5. resetb driven low mid-word → all outputs take reset values immediately (asynchronously); after release the next frame transfers 8'h5A correctly.
6. tx_valid asserted in the same clk as a word-boundary load with the buffer empty → the current word is FF with a tx_underrun pulse, and the written word is sent as the next word.
